uart_rx_capture: RTL and testbench



---
 rtl/uart_rx_capture_if.sv | 12 +
 rtl/uart_rx_capture.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx_capture.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_capture_if.sv
// Read-side bundle of the UART receive FIFO: pop request, head data and status flags.
interface uart_rx_capture_if #(
  parameter int DATA_BITS = 8
);
  logic                 rd_en;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_valid;
  logic                 fifo_full;

  modport master (output rd_en, input rd_data, rd_valid, fifo_full);
  modport slave  (input rd_en, output rd_data, rd_valid, fifo_full);
endinterface

// File: rtl/uart_rx_capture.sv
// Oversampling UART receiver with optional parity, FWFT receive FIFO, LED mirror
// and saturating error counter.
module uart_rx_capture #(
  parameter int                   CLKS_PER_BIT = 434,
  parameter int                   DATA_BITS    = 8,
  parameter int                   PARITY       = 0,
  parameter int                   FIFO_DEPTH   = 8,
  parameter logic [DATA_BITS-1:0] ERR_LED      = '1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  uart_rx_capture_if.slave     rd,
  output logic [DATA_BITS-1:0] LEDS,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 overrun,
  output logic [7:0]           error_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Odd mode wants an odd count of ones over data plus parity bit, even mode an even count.
  function automatic logic parity_good(input logic [DATA_BITS-1:0] d, input logic p);
    logic ones;
    ones = ^{d, p};
    return (PARITY == 1) ? ones : ~ones;
  endfunction

  logic                 sync1_q, rxs_q;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bitn_q, bitn_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_ok_q, par_ok_d;
  logic                 done;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 empty, full, push, pop;

  logic [DATA_BITS-1:0] leds_q, leds_d;
  logic                 fe_q, fe_d, pe_q, pe_d, ov_q, ov_d;
  logic [7:0]           err_q, err_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitn_d   = bitn_q;
    shift_d  = shift_q;
    par_ok_d = par_ok_q;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            state_d  = S_DATA;
            bitn_d   = '0;
            par_ok_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          bitn_d  = bitn_q + 1'b1;
          if (bitn_q == LAST_BIT) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d    = '0;
          par_ok_d = parity_good(shift_q, rxs_q);
          state_d  = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          done    = 1'b1;
          state_d = rxs_q ? S_IDLE : S_BREAK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = rd.rd_en && !empty;

  // A full FIFO still accepts the character when the same cycle frees a slot.
  always_comb begin
    push   = 1'b0;
    fe_d   = 1'b0;
    pe_d   = 1'b0;
    ov_d   = 1'b0;
    leds_d = leds_q;
    err_d  = err_q;
    if (done) begin
      if (!rxs_q) begin
        fe_d   = 1'b1;
        leds_d = ERR_LED;
        err_d  = sat_inc(err_q);
      end else if (!par_ok_q) begin
        pe_d   = 1'b1;
        leds_d = ERR_LED;
        err_d  = sat_inc(err_q);
      end else begin
        leds_d = shift_q;
        if (!full || pop) begin
          push = 1'b1;
        end else begin
          ov_d  = 1'b1;
          err_d = sat_inc(err_q);
        end
      end
    end
  end

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bitn_q   <= '0;
      shift_q  <= '0;
      par_ok_q <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      leds_q   <= '0;
      fe_q     <= 1'b0;
      pe_q     <= 1'b0;
      ov_q     <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitn_q   <= bitn_d;
      shift_q  <= shift_d;
      par_ok_q <= par_ok_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      leds_q   <= leds_d;
      fe_q     <= fe_d;
      pe_q     <= pe_d;
      ov_q     <= ov_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  assign rd.rd_data   = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  assign rd.rd_valid  = !empty;
  assign rd.fifo_full = full;

  assign LEDS         = leds_q;
  assign frame_error  = fe_q;
  assign parity_error = pe_q;
  assign overrun      = ov_q;
  assign error_count  = err_q;

endmodule

// File: tb/tb_uart_rx_capture.sv
// Randomised bench for uart_rx_capture: a no-parity/4-deep and an even-parity/8-deep
// instance checked against a queue-based frame model.
`timescale 1ns/1ps
module tb_uart_rx_capture;
  localparam int CPB = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_v     [2];
  logic       rd_en_v  [2];
  logic [7:0] leds_v   [2];
  logic       fe_v     [2];
  logic       pe_v     [2];
  logic       ov_v     [2];
  logic [7:0] ec_v     [2];
  logic       rdv      [2];
  logic       fl       [2];
  logic [7:0] rdd      [2];

  uart_rx_capture_if #(.DATA_BITS(8)) bus0 ();
  uart_rx_capture_if #(.DATA_BITS(8)) bus1 ();

  assign bus0.rd_en = rd_en_v[0];
  assign bus1.rd_en = rd_en_v[1];
  assign rdv[0] = bus0.rd_valid;
  assign rdv[1] = bus1.rd_valid;
  assign fl[0]  = bus0.fifo_full;
  assign fl[1]  = bus1.fifo_full;
  assign rdd[0] = bus0.rd_data;
  assign rdd[1] = bus1.rd_data;

  uart_rx_capture #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) dut0 (
    .clock(clock), .reset(reset), .rx(rx_v[0]), .rd(bus0.slave), .LEDS(leds_v[0]),
    .frame_error(fe_v[0]), .parity_error(pe_v[0]), .overrun(ov_v[0]), .error_count(ec_v[0]));

  uart_rx_capture #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(8)) dut1 (
    .clock(clock), .reset(reset), .rx(rx_v[1]), .rd(bus1.slave), .LEDS(leds_v[1]),
    .frame_error(fe_v[1]), .parity_error(pe_v[1]), .overrun(ov_v[1]), .error_count(ec_v[1]));

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_n [2] = '{0, 0};

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++)
      if (fe_v[i] || pe_v[i] || ov_v[i]) pulse_n[i] <= pulse_n[i] + 1;
  end

  // Reference model: expected FIFO contents, LED value and error count per instance.
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int         depth   [2] = '{4, 8};
  logic [7:0] exp_leds [2];
  int         exp_ec   [2];

  function automatic int qsize(input int s);
    return (s != 0) ? q1.size() : q0.size();
  endfunction

  function automatic logic [7:0] qhead(input int s);
    return (s != 0) ? q1[0] : q0[0];
  endfunction

  task automatic qpop(input int s);
    if (s != 0) void'(q1.pop_front());
    else        void'(q0.pop_front());
  endtask

  task automatic qpush(input int s, input logic [7:0] d);
    if (s != 0) q1.push_back(d);
    else        q0.push_back(d);
  endtask

  task automatic bump_err(input int s);
    exp_ec[s] = (exp_ec[s] >= 255) ? 255 : exp_ec[s] + 1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input int s);
    check_eq({tag, "_leds"},  leds_v[s], exp_leds[s]);
    check_eq({tag, "_ecnt"},  ec_v[s], exp_ec[s]);
    check_eq({tag, "_valid"}, rdv[s], qsize(s) != 0);
    check_eq({tag, "_full"},  fl[s], qsize(s) == depth[s]);
    if (qsize(s) != 0) check_eq({tag, "_head"}, rdd[s], qhead(s));
  endtask

  // Serial line: start, data LSB first, even parity on instance 1, then stop.
  task automatic drive_bits(input int s, input logic [7:0] d, input logic flip, input int stop_low);
    rx_v[s] = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx_v[s] = d[i];
      repeat (CPB) @(negedge clock);
    end
    if (s != 0) begin
      rx_v[s] = (^d) ^ flip;
      repeat (CPB) @(negedge clock);
    end
    if (stop_low > 0) begin
      rx_v[s] = 1'b0;
      repeat (CPB * stop_low) @(negedge clock);
    end
    rx_v[s] = 1'b1;
    repeat (CPB) @(negedge clock);
  endtask

  // Completion-cycle checks: nothing visible before the edge after the stop sample, all of it after.
  task automatic watch(input int s, input logic [7:0] d, input logic flip, input int stop_low,
                       input logic rd_req);
    int   k;
    logic efe, epe, eov;
    k   = 9 + (9 + s) * CPB;
    efe = 1'b0;
    epe = 1'b0;
    eov = 1'b0;
    repeat (k + 1) @(posedge clock);
    @(negedge clock);
    check_state("pre", s);
    check_eq("pre_pulse", {fe_v[s], pe_v[s], ov_v[s]}, 0);
    if (rd_req) begin
      rd_en_v[s] = 1'b1;
      if (qsize(s) != 0) qpop(s);
    end
    if (stop_low > 0) begin
      efe = 1'b1;
      exp_leds[s] = 8'hFF;
      bump_err(s);
    end else if (s != 0 && flip) begin
      epe = 1'b1;
      exp_leds[s] = 8'hFF;
      bump_err(s);
    end else begin
      exp_leds[s] = d;
      if (qsize(s) < depth[s]) qpush(s, d);
      else begin
        eov = 1'b1;
        bump_err(s);
      end
    end
    @(negedge clock);
    rd_en_v[s] = 1'b0;
    check_state("post", s);
    check_eq("frame_error", fe_v[s], efe);
    check_eq("parity_error", pe_v[s], epe);
    check_eq("overrun", ov_v[s], eov);
    @(negedge clock);
    check_eq("pulse_width", {fe_v[s], pe_v[s], ov_v[s]}, 0);
  endtask

  task automatic frame(input int s, input logic [7:0] d, input logic flip, input int stop_low,
                       input logic rd_req);
    fork
      drive_bits(s, d, flip, stop_low);
      watch(s, d, flip, stop_low, rd_req);
    join
  endtask

  task automatic pop_chk(input int s);
    check_eq("pop_valid", rdv[s], qsize(s) != 0);
    if (qsize(s) != 0) begin
      check_eq("pop_data", rdd[s], qhead(s));
      qpop(s);
    end
    rd_en_v[s] = 1'b1;
    @(negedge clock);
    rd_en_v[s] = 1'b0;
    check_state("after_pop", s);
  endtask

  task automatic drain(input int s);
    while (qsize(s) != 0) pop_chk(s);
    pop_chk(s);
  endtask

  initial begin
    int s, stop_low, p0, p1;
    logic [7:0] d;
    logic flip, rdq;

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rx_v[i]     = 1'b1;
      rd_en_v[i]  = 1'b0;
      exp_leds[i] = 8'h00;
      exp_ec[i]   = 0;
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check_state("reset", i);
      check_eq("reset_rd_data", rdd[i], 0);
      check_eq("reset_pulse", {fe_v[i], pe_v[i], ov_v[i]}, 0);
    end

    frame(0, 8'hA5, 1'b0, 0, 1'b0);
    drain(0);

    frame(1, 8'h03, 1'b0, 0, 1'b0);
    frame(1, 8'h03, 1'b1, 0, 1'b0);
    drain(1);

    frame(0, 8'h55, 1'b0, 3, 1'b0);
    frame(0, 8'h12, 1'b0, 0, 1'b0);
    drain(0);

    for (int i = 0; i < 2; i++) begin
      p0 = pulse_n[i];
      rx_v[i] = 1'b0;
      repeat (3) @(negedge clock);
      rx_v[i] = 1'b1;
      repeat (3 * CPB) @(negedge clock);
      check_eq("glitch_pulses", pulse_n[i], p0);
      check_state("glitch", i);
    end

    for (int i = 1; i <= 5; i++) frame(0, 8'(i), 1'b0, 0, 1'b0);
    drain(0);
    for (int i = 1; i <= 5; i++) frame(0, 8'(i), 1'b0, 0, i == 5);
    drain(0);

    for (int i = 0; i < 20; i++) begin
      frame(0, 8'(i), 1'b0, 0, 1'b0);
      pop_chk(0);
    end

    repeat (30) begin
      s        = $urandom_range(0, 1);
      d        = 8'($urandom);
      flip     = (s != 0) && ($urandom_range(0, 4) == 0);
      stop_low = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
      rdq      = ($urandom_range(0, 3) == 0);
      frame(s, d, flip, stop_low, rdq);
      if ($urandom_range(0, 1) == 1) pop_chk(s);
    end

    frame(0, 8'($urandom), 1'b0, 0, 1'b0);
    p0 = pulse_n[0];
    p1 = pulse_n[1];
    rx_v[0] = 1'b0;
    repeat (CPB) @(negedge clock);
    rx_v[0] = 1'b1;
    repeat (4 * CPB + 8) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      exp_leds[i] = 8'h00;
      exp_ec[i]   = 0;
    end
    repeat (2 * CPB) @(negedge clock);
    check_eq("rst_pulses0", pulse_n[0], p0);
    check_eq("rst_pulses1", pulse_n[1], p1);
    check_state("rst_mid0", 0);
    check_state("rst_mid1", 1);
    frame(0, 8'h3C, 1'b0, 0, 1'b0);
    drain(0);

    repeat (260) frame(0, 8'($urandom), 1'b0, 1, 1'b0);
    check_eq("ecnt_saturated", ec_v[0], 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
